// File: rtl/axi_typedef_pkg.sv
// Shared AXI crossbar types: master index, burst descriptors and the
// AW arbiter state encodings.
package axi_typedef_pkg;

  localparam int unsigned XBAR_NUM_MST = 4;
  localparam int unsigned MST_IDX_W    = (XBAR_NUM_MST > 1) ? $clog2(XBAR_NUM_MST) : 1;

  typedef logic [MST_IDX_W-1:0] mst_idx_t;
  typedef logic [7:0]           len_t;
  typedef logic [2:0]           size_t;
  typedef logic [1:0]           burst_t;

  localparam logic [0:0] AW_IDLE   = 1'b0;
  localparam logic [0:0] AW_LOCKED = 1'b1;

endpackage

// File: rtl/axi_route_fifo.sv
// Route FIFO holding granted master indices in AW acceptance order.
// Extra pointer MSB tells full from empty when the address bits match.
module axi_route_fifo
  import axi_typedef_pkg::*;
#(
  parameter int unsigned DEPTH = 4,
  parameter type         idx_t = mst_idx_t
) (
  input  logic clk,
  input  logic rst_n,
  input  logic push,
  input  idx_t push_idx,
  input  logic pop,
  output logic full,
  output logic empty,
  output idx_t head
);

  localparam int unsigned PTR_W = $clog2(DEPTH);

  logic [PTR_W:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W:0] rd_ptr_q, rd_ptr_d;
  idx_t           mem_q [DEPTH];
  idx_t           mem_d [DEPTH];

  assign empty = (wr_ptr_q == rd_ptr_q);
  assign full  = (wr_ptr_q[PTR_W] != rd_ptr_q[PTR_W]) &&
                 (wr_ptr_q[PTR_W-1:0] == rd_ptr_q[PTR_W-1:0]);
  assign head  = mem_q[rd_ptr_q[PTR_W-1:0]];

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (push && !full) begin
      mem_d[wr_ptr_q[PTR_W-1:0]] = push_idx;
      wr_ptr_d                   = wr_ptr_q + (PTR_W+1)'(1);
    end
    if (pop && !empty) begin
      rd_ptr_d = rd_ptr_q + (PTR_W+1)'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      mem_q    <= mem_d;
    end
  end

endmodule

// File: rtl/axi_aw_w_arbiter.sv
// Round-robin AW arbiter for one crossbar slave port; W follows the
// recorded AW grant order one whole burst at a time.
//
//   state     | meaning
//   AW_IDLE   | free to pick the next requester at or after rr_ptr
//   AW_LOCKED | AW offered but not accepted; grant held on lock_idx
module axi_aw_w_arbiter
  import axi_typedef_pkg::*;
#(
  parameter int unsigned NUM_MST     = 4,
  parameter int unsigned AW_W        = 64,
  parameter int unsigned W_W         = 80,
  parameter int unsigned ROUTE_DEPTH = 4
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic [NUM_MST-1:0]           mst_aw_valid,
  output logic [NUM_MST-1:0]           mst_aw_ready,
  input  logic [NUM_MST*AW_W-1:0]      mst_aw_payload,
  input  logic [NUM_MST-1:0]           mst_w_valid,
  output logic [NUM_MST-1:0]           mst_w_ready,
  input  logic [NUM_MST-1:0]           mst_w_last,
  input  logic [NUM_MST*W_W-1:0]       mst_w_payload,
  output logic                         slv_aw_valid,
  input  logic                         slv_aw_ready,
  output logic [AW_W-1:0]              slv_aw_payload,
  output logic [$clog2(NUM_MST)-1:0]   slv_aw_sel,
  output logic                         slv_w_valid,
  input  logic                         slv_w_ready,
  output logic                         slv_w_last,
  output logic [W_W-1:0]               slv_w_payload
);

  localparam int unsigned IDX_W = $clog2(NUM_MST);
  typedef logic [IDX_W-1:0] idx_t;

  logic [0:0]    state_q, state_d;
  idx_t          lock_idx_q, lock_idx_d;
  idx_t          rr_ptr_q, rr_ptr_d;

  logic [AW_W-1:0] aw_pl [NUM_MST];
  logic [W_W-1:0]  w_pl  [NUM_MST];

  for (genvar g = 0; g < NUM_MST; g++) begin : g_unpack
    assign aw_pl[g] = mst_aw_payload[g*AW_W +: AW_W];
    assign w_pl[g]  = mst_w_payload[g*W_W +: W_W];
  end

  logic        fifo_full;
  logic        fifo_empty;
  idx_t        fifo_head;

  int unsigned rr_cand;
  idx_t        rr_cand_idx;
  idx_t        rr_pick;
  logic        rr_found;

  always_comb begin
    rr_cand     = 0;
    rr_cand_idx = '0;
    rr_pick     = '0;
    rr_found    = 1'b0;
    for (int unsigned off = 0; off < NUM_MST; off++) begin
      rr_cand = {{(32-IDX_W){1'b0}}, rr_ptr_q} + off;
      if (rr_cand >= NUM_MST) begin
        rr_cand = rr_cand - NUM_MST;
      end
      rr_cand_idx = rr_cand[IDX_W-1:0];
      if (!rr_found && mst_aw_valid[rr_cand_idx]) begin
        rr_found = 1'b1;
        rr_pick  = rr_cand_idx;
      end
    end
  end

  logic aw_locked;
  idx_t grant_idx;
  logic grant_vld;
  logic aw_hs;

  // A locked grant never needs the full check: it was taken while not full
  // and nothing else can push in between.
  assign aw_locked = (state_q == AW_LOCKED);
  assign grant_idx = aw_locked ? lock_idx_q : rr_pick;
  assign grant_vld = aw_locked | (rr_found & ~fifo_full);
  assign aw_hs     = grant_vld & slv_aw_ready;

  always_comb begin
    slv_aw_valid   = grant_vld;
    slv_aw_sel     = '0;
    slv_aw_payload = '0;
    mst_aw_ready   = '0;
    if (grant_vld) begin
      slv_aw_sel              = grant_idx;
      slv_aw_payload          = aw_pl[grant_idx];
      mst_aw_ready[grant_idx] = slv_aw_ready;
    end
  end

  always_comb begin
    state_d    = state_q;
    lock_idx_d = lock_idx_q;
    rr_ptr_d   = rr_ptr_q;
    case (state_q)
      AW_IDLE: begin
        if (grant_vld && !slv_aw_ready) begin
          state_d    = AW_LOCKED;
          lock_idx_d = grant_idx;
        end
      end
      AW_LOCKED: begin
        if (slv_aw_ready) begin
          state_d = AW_IDLE;
        end
      end
      default: state_d = AW_IDLE;
    endcase
    if (aw_hs) begin
      rr_ptr_d = (grant_idx == idx_t'(NUM_MST-1)) ? '0 : grant_idx + idx_t'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= AW_IDLE;
      lock_idx_q <= '0;
      rr_ptr_q   <= '0;
    end else begin
      state_q    <= state_d;
      lock_idx_q <= lock_idx_d;
      rr_ptr_q   <= rr_ptr_d;
    end
  end

  logic w_pop;

  always_comb begin
    slv_w_valid   = 1'b0;
    slv_w_last    = 1'b0;
    slv_w_payload = '0;
    mst_w_ready   = '0;
    if (!fifo_empty) begin
      slv_w_valid            = mst_w_valid[fifo_head];
      slv_w_last             = mst_w_last[fifo_head];
      slv_w_payload          = w_pl[fifo_head];
      mst_w_ready[fifo_head] = slv_w_ready;
    end
  end

  assign w_pop = slv_w_valid & slv_w_ready & slv_w_last;

  axi_route_fifo #(
    .DEPTH (ROUTE_DEPTH),
    .idx_t (idx_t)
  ) u_route_fifo (
    .clk      (clk),
    .rst_n    (rst_n),
    .push     (aw_hs),
    .push_idx (grant_idx),
    .pop      (w_pop),
    .full     (fifo_full),
    .empty    (fifo_empty),
    .head     (fifo_head)
  );

endmodule
